traceback_controller: RTL and testbench
=======================================

TRACEBACK_CONTROLLER -- requirements
Module: traceback_controller

Interface
REQ-001 Parameter N, default 128, maximum sequence length (matrix is (N+1)x(N+1)).
REQ-002 Parameter BitAddr, default $clog2(N+1), index width minus one.
REQ-003 Parameter RD_LAT, default 2, cycles from en_traceB rising with stable i_t/j_t to valid symbol_in.
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 start  input  1  one-cycle pulse, begin traceback from (len_a,len_b); ignored unless IDLE or DONE.
REQ-007 len_a, len_b  input  BitAddr+1 each  sequence lengths, sampled on accepted start, valid range 0..N.
REQ-008 en_traceB  output  1  read enable to direction manager.
REQ-009 i_t, j_t  output  BitAddr+1 each  traceback cell indices to direction manager.
REQ-010 symbol_in  input  3  direction symbol read back (100 diag, 010 up, 001 left, others invalid).
REQ-011 out_valid  output  1  alignment step available.
REQ-012 out_ready  input  1  downstream accepts step when high with out_valid.
REQ-013 out_op  output  2  step code: 00 match/mismatch, 01 gap in B (up), 10 gap in A (left).
REQ-014 out_i, out_j  output  BitAddr+1 each  cell indices of emitted step, before the move.
REQ-015 busy, done, error  output  1 each  status flags.

Function
REQ-016 FSM states: IDLE, ADDR, WAIT, DECODE, EMIT, DONE.
REQ-017 IDLE/DONE + start: load i=len_a, j=len_b, clear done/error, step counter=0; go ADDR.
REQ-018 ADDR: if i==0 and j==0 go DONE with done=1; if i==0 set op=10 and go EMIT without read; if j==0 set op=01 and go EMIT without read; else assert en_traceB, go WAIT.
REQ-019 WAIT: hold en_traceB=1 and i_t/j_t stable for exactly RD_LAT cycles, then go DECODE.
REQ-020 DECODE: en_traceB=0; 100->op 00, 010->op 01, 001->op 10, go EMIT; any other value -> error=1, go DONE.
REQ-021 EMIT: out_valid=1, out_op/out_i/out_j stable until out_valid&&out_ready; on that cycle apply move (00: i-1,j-1; 01: i-1; 10: j-1), step counter+1, go ADDR.
REQ-022 out_valid SHALL never deassert in EMIT without a handshake.
REQ-023 Step counter width BitAddr+2; a handshake that would make it exceed len_a+len_b sets error=1, go DONE.
REQ-024 Indices never decrement below 0; a decoded move that would do so (e.g. diag with i==0) sets error=1, go DONE.
REQ-025 i_t/j_t driven from i/j at all times; en_traceB high only in ADDR (read branch) and WAIT.
REQ-026 busy=1 in every state except IDLE and DONE.
REQ-027 done and error are sticky until next accepted start or reset.
REQ-028 start while busy is ignored, no state change.
REQ-029 len_a or len_b greater than N on start: error=1, go DONE directly, no reads.
REQ-030 Per read step latency start-of-ADDR to out_valid = RD_LAT+2 cycles with out_ready held high.

Reset
REQ-031 rst=1 forces IDLE asynchronously; i, j, step counter = 0.
REQ-032 During reset: en_traceB=0, out_valid=0, out_op=00, out_i=out_j=0, busy=done=error=0.
REQ-033 Reset mid-traceback abandons it; no further out_valid until next start after release.

Structure
REQ-034 Shared package holds symbol encodings (DIAG=100, UP=010, LEFT=001), out_op codes, FSM state encoding.
REQ-035 One sub-module: tb_step_decoder (combinational symbol+i/j -> op, illegal flag); everything else in top.
REQ-036 Top instantiates alongside direction manager: i_t/j_t/en_traceB feed it, symbol_out feeds symbol_in.

Verification
REQ-037 N=4, len 4/4, RAM diagonal everywhere, out_ready=1 -> 4 steps op 00 at (4,4),(3,3),(2,2),(1,1), then done=1.
REQ-038 len_a=2, len_b=0, start -> 2 steps op 01 at (2,0),(1,0), en_traceB never high, done=1.
REQ-039 Cell (3,3) holds 000, start len 3/3 -> error=1, done=0, no out_valid after decode.
REQ-040 out_ready low 5 cycles during EMIT -> out_valid, out_op, out_i, out_j stable all 5 cycles; single step counted.
REQ-041 rst pulse while in WAIT -> all outputs reset values same cycle; start after release restarts at (len_a,len_b).
REQ-042 Mixed path (4,4) diag,left,up,diag,diag -> ops 00,10,01,00,00 at (4,4),(3,3),(3,2),(2,2),(1,1); start pulses while busy ignored.

Source files
------------

// File: rtl/traceback_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module   : traceback_controller_pkg
// Purpose  : Shared direction-symbol and step-op encodings plus FSM states.
// Revision : 1.0
// ============================================================================
package traceback_controller_pkg;

  localparam logic [2:0] SYM_DIAG = 3'b100;
  localparam logic [2:0] SYM_UP   = 3'b010;
  localparam logic [2:0] SYM_LEFT = 3'b001;

  localparam logic [1:0] OP_DIAG  = 2'b00;
  localparam logic [1:0] OP_UP    = 2'b01;
  localparam logic [1:0] OP_LEFT  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADDR   = 3'd1,
    ST_WAIT   = 3'd2,
    ST_DECODE = 3'd3,
    ST_EMIT   = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

endpackage
`default_nettype wire

// File: rtl/traceback_controller_tb_step_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_step_decoder
// Purpose  : Maps a direction symbol to a step op; flags unknown symbols and
//            moves that would take an index below zero.
// Revision : 1.0
// ============================================================================
module tb_step_decoder
  import traceback_controller_pkg::*;
#(
  parameter int IW = 9
) (
  input  logic [2:0]    symbol_i,
  input  logic [IW-1:0] i_i,
  input  logic [IW-1:0] j_i,
  output logic [1:0]    op_o,
  output logic          illegal_o
);

  logic w_i_zero;
  logic w_j_zero;

  assign w_i_zero = (i_i == '0);
  assign w_j_zero = (j_i == '0);

  always_comb begin
    op_o      = OP_DIAG;
    illegal_o = 1'b0;
    case (symbol_i)
      SYM_DIAG: begin
        op_o      = OP_DIAG;
        illegal_o = w_i_zero || w_j_zero;
      end
      SYM_UP: begin
        op_o      = OP_UP;
        illegal_o = w_i_zero;
      end
      SYM_LEFT: begin
        op_o      = OP_LEFT;
        illegal_o = w_j_zero;
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/traceback_controller.sv
`default_nettype none
// ============================================================================
// Module   : traceback_controller
// Purpose  : Walks the alignment direction matrix from (len_a,len_b) back to
//            (0,0), emitting one alignment step per valid/ready handshake.
// Revision : 1.0
// ============================================================================
module traceback_controller
  import traceback_controller_pkg::*;
#(
  parameter int N       = 128,
  parameter int BitAddr = $clog2(N + 1),
  parameter int RD_LAT  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [BitAddr:0] len_a,
  input  logic [BitAddr:0] len_b,
  output logic             en_traceB,
  output logic [BitAddr:0] i_t,
  output logic [BitAddr:0] j_t,
  input  logic [2:0]       symbol_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_op,
  output logic [BitAddr:0] out_i,
  output logic [BitAddr:0] out_j,
  output logic             busy,
  output logic             done,
  output logic             error
);

  localparam int IW = BitAddr + 1;
  localparam int CW = BitAddr + 2;
  localparam int WW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [IW-1:0] NMAX  = IW'(N);
  localparam logic [WW-1:0] WLAST = WW'(RD_LAT - 1);

  state_e        state_q, state_d;
  logic [IW-1:0] i_q, i_d;
  logic [IW-1:0] j_q, j_d;
  logic [CW-1:0] step_q, step_d;
  logic [CW-1:0] lsum_q, lsum_d;
  logic [1:0]    op_q, op_d;
  logic          done_q, done_d;
  logic          error_q, error_d;
  logic [WW-1:0] wcnt_q, wcnt_d;

  logic [1:0]    w_dec_op;
  logic          w_dec_illegal;
  logic [CW-1:0] w_step_inc;
  logic          w_rd_en;

  tb_step_decoder #(
    .IW (IW)
  ) u_step_decoder (
    .symbol_i  (symbol_in),
    .i_i       (i_q),
    .j_i       (j_q),
    .op_o      (w_dec_op),
    .illegal_o (w_dec_illegal)
  );

  assign w_step_inc = step_q + CW'(1);

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    step_d  = step_q;
    lsum_d  = lsum_q;
    op_d    = op_q;
    done_d  = done_q;
    error_d = error_q;
    wcnt_d  = wcnt_q;
    w_rd_en = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          if ((len_a > NMAX) || (len_b > NMAX)) begin
            done_d  = 1'b0;
            error_d = 1'b1;
            state_d = ST_DONE;
          end else begin
            i_d     = len_a;
            j_d     = len_b;
            step_d  = '0;
            lsum_d  = CW'(len_a) + CW'(len_b);
            done_d  = 1'b0;
            error_d = 1'b0;
            state_d = ST_ADDR;
          end
        end
      end

      ST_ADDR: begin
        // Border cells have only one legal move, so no matrix read is needed.
        if ((i_q == '0) && (j_q == '0)) begin
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else if (i_q == '0) begin
          op_d    = OP_LEFT;
          state_d = ST_EMIT;
        end else if (j_q == '0) begin
          op_d    = OP_UP;
          state_d = ST_EMIT;
        end else begin
          w_rd_en = 1'b1;
          wcnt_d  = '0;
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        w_rd_en = 1'b1;
        if (wcnt_q == WLAST) begin
          state_d = ST_DECODE;
        end else begin
          wcnt_d = wcnt_q + WW'(1);
        end
      end

      ST_DECODE: begin
        if (w_dec_illegal) begin
          error_d = 1'b1;
          state_d = ST_DONE;
        end else begin
          op_d    = w_dec_op;
          state_d = ST_EMIT;
        end
      end

      ST_EMIT: begin
        if (out_ready) begin
          if (w_step_inc > lsum_q) begin
            error_d = 1'b1;
            state_d = ST_DONE;
          end else begin
            step_d = w_step_inc;
            case (op_q)
              OP_DIAG: begin
                i_d = i_q - IW'(1);
                j_d = j_q - IW'(1);
              end
              OP_UP:   i_d = i_q - IW'(1);
              default: j_d = j_q - IW'(1);
            endcase
            state_d = ST_ADDR;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      step_q  <= '0;
      lsum_q  <= '0;
      op_q    <= OP_DIAG;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      step_q  <= step_d;
      lsum_q  <= lsum_d;
      op_q    <= op_d;
      done_q  <= done_d;
      error_q <= error_d;
      wcnt_q  <= wcnt_d;
    end
  end

  assign en_traceB = w_rd_en;
  assign i_t       = i_q;
  assign j_t       = j_q;
  assign out_valid = (state_q == ST_EMIT);
  assign out_op    = op_q;
  assign out_i     = i_q;
  assign out_j     = j_q;
  assign busy      = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done      = done_q;
  assign error     = error_q;

endmodule
`default_nettype wire

// File: tb/tb_traceback_controller.sv
`default_nettype none
// Bench for traceback_controller: scripted scenarios plus randomized matrices,
// checked against a direct walk of the direction matrix.
module tb_traceback_controller;

  localparam int N      = 4;
  localparam int RD_LAT = 2;
  localparam int BA     = $clog2(N + 1);
  localparam int IW     = BA + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [IW-1:0] len_a = '0;
  logic [IW-1:0] len_b = '0;
  logic          out_ready = 1'b1;
  logic          en_traceB;
  logic [IW-1:0] i_t, j_t, out_i, out_j;
  logic [2:0]    symbol_in;
  logic          out_valid, busy, done, error;
  logic [1:0]    out_op;

  traceback_controller #(.N(N), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .len_a(len_a), .len_b(len_b),
    .en_traceB(en_traceB), .i_t(i_t), .j_t(j_t), .symbol_in(symbol_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
    .out_i(out_i), .out_j(out_j), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  // Direction memory: symbol appears RD_LAT cycles after the read is issued.
  logic [2:0] mem [0:N][0:N];
  logic [2:0] rd_p0 = 3'b111;
  logic [2:0] rd_p1 = 3'b111;
  always @(posedge clk) begin
    rd_p0 <= (en_traceB && i_t <= IW'(N) && j_t <= IW'(N)) ? mem[i_t][j_t] : 3'b111;
    rd_p1 <= rd_p0;
  end
  assign symbol_in = rd_p1;

  int total = 0;
  int bad   = 0;

  int cap_op[$], cap_i[$], cap_j[$];
  int exp_op[$], exp_i[$], exp_j[$];
  int en_cycles, first_en, first_v;
  bit end_done, end_err, exp_done, exp_err;

  task automatic fill_mem(input logic [2:0] s);
    for (int a = 0; a <= N; a++)
      for (int b = 0; b <= N; b++) mem[a][b] = s;
  endtask

  // Reference: follow the matrix from (a,b) to the origin.
  task automatic model_trace(input int a, input int b);
    int i, j;
    exp_op = {}; exp_i = {}; exp_j = {};
    exp_done = 0; exp_err = 0;
    if (a > N || b > N) begin
      exp_err = 1;
      return;
    end
    i = a; j = b;
    forever begin
      if (i == 0 && j == 0) begin exp_done = 1; break; end
      exp_i.push_back(i); exp_j.push_back(j);
      if (i == 0) begin exp_op.push_back(2); j--; end
      else if (j == 0) begin exp_op.push_back(1); i--; end
      else begin
        case (mem[i][j])
          3'b100: begin exp_op.push_back(0); i--; j--; end
          3'b010: begin exp_op.push_back(1); i--; end
          3'b001: begin exp_op.push_back(2); j--; end
          default: begin
            exp_i.pop_back(); exp_j.pop_back();
            exp_err = 1;
            break;
          end
        endcase
      end
    end
  endtask

  // Drive one traceback and record handshakes; checks EMIT stability on stalls.
  task automatic run_trace(input int a, input int b, input int ready_pct,
                           input int stall_n, input bit inject);
    int c;
    int stalls;
    bit prev_v, prev_hs, hs;
    logic [1:0] p_op;
    logic [IW-1:0] p_i, p_j;
    cap_op = {}; cap_i = {}; cap_j = {};
    en_cycles = 0; first_en = -1; first_v = -1;
    stalls = stall_n; prev_v = 0; prev_hs = 0;
    p_op = '0; p_i = '0; p_j = '0;
    @(negedge clk);
    len_a = IW'(a); len_b = IW'(b); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    c = 0;
    while (busy && c < 600) begin
      if (en_traceB) begin
        en_cycles++;
        if (first_en < 0) first_en = c;
      end
      if (out_valid && first_v < 0) first_v = c;
      if (prev_v && !prev_hs) begin
        total++;
        if (!out_valid || out_op !== p_op || out_i !== p_i || out_j !== p_j) begin
          bad++;
          $display("FAIL emit_hold: got v=%0b op=%0d (%0d,%0d) need v=1 op=%0d (%0d,%0d)",
                   out_valid, out_op, out_i, out_j, p_op, p_i, p_j);
        end
      end
      if (out_valid && stalls > 0) begin
        out_ready = 1'b0;
        stalls--;
      end else begin
        out_ready = ($urandom_range(99) < ready_pct);
      end
      if (inject && ($urandom_range(2) == 0)) begin
        start = 1'b1;
        len_a = IW'($urandom_range(15));
        len_b = IW'($urandom_range(15));
      end else begin
        start = 1'b0;
      end
      hs = out_valid && out_ready;
      if (hs) begin
        cap_op.push_back(int'(out_op));
        cap_i.push_back(int'(out_i));
        cap_j.push_back(int'(out_j));
      end
      prev_v = out_valid; prev_hs = hs;
      p_op = out_op; p_i = out_i; p_j = out_j;
      @(negedge clk);
      c++;
    end
    start = 1'b0;
    out_ready = 1'b1;
    if (busy) begin
      total++; bad++;
      $display("FAIL trace_timeout: busy=%0b after %0d cycles need busy=0", busy, c);
    end
    end_done = done;
    end_err  = error;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({en_traceB, out_valid, out_op, out_i, out_j, busy, done, error} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: en=%0b v=%0b op=%0d i=%0d j=%0d busy=%0b done=%0b err=%0b need all 0",
               en_traceB, out_valid, out_op, out_i, out_j, busy, done, error);
    end
    total++;
    if (i_t !== '0 || j_t !== '0) begin
      bad++;
      $display("FAIL reset_index: i_t=%0d j_t=%0d need 0,0", i_t, j_t);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_diagonal;
    fill_mem(3'b100);
    run_trace(4, 4, 100, 0, 0);
    exp_op = {0, 0, 0, 0}; exp_i = {4, 3, 2, 1}; exp_j = {4, 3, 2, 1};
    total++;
    if (cap_op.size() != 4) begin
      bad++;
      $display("FAIL diag_count: got %0d steps need 4", cap_op.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        total++;
        if (cap_op[k] != exp_op[k] || cap_i[k] != exp_i[k] || cap_j[k] != exp_j[k]) begin
          bad++;
          $display("FAIL diag_step%0d: got op=%0d (%0d,%0d) need op=%0d (%0d,%0d)",
                   k, cap_op[k], cap_i[k], cap_j[k], exp_op[k], exp_i[k], exp_j[k]);
        end
      end
    end
    total++;
    if (end_done !== 1'b1 || end_err !== 1'b0) begin
      bad++;
      $display("FAIL diag_status: got done=%0b err=%0b need done=1 err=0", end_done, end_err);
    end
    total++;
    if (en_cycles != 4 * (RD_LAT + 1)) begin
      bad++;
      $display("FAIL diag_read_cycles: got %0d need %0d", en_cycles, 4 * (RD_LAT + 1));
    end
  endtask

  task automatic test_latency;
    fill_mem(3'b100);
    run_trace(1, 1, 100, 0, 0);
    total++;
    if (first_en < 0 || first_v < 0 || (first_v - first_en) != RD_LAT + 2) begin
      bad++;
      $display("FAIL read_latency: got en@%0d valid@%0d need gap %0d", first_en, first_v, RD_LAT + 2);
    end
  endtask

  task automatic test_gap_only;
    fill_mem(3'b000);
    run_trace(2, 0, 100, 0, 0);
    total++;
    if (cap_op.size() != 2) begin
      bad++;
      $display("FAIL gap_count: got %0d steps need 2", cap_op.size());
    end else begin
      for (int k = 0; k < 2; k++) begin
        total++;
        if (cap_op[k] != 1 || cap_i[k] != 2 - k || cap_j[k] != 0) begin
          bad++;
          $display("FAIL gap_step%0d: got op=%0d (%0d,%0d) need op=1 (%0d,0)",
                   k, cap_op[k], cap_i[k], cap_j[k], 2 - k);
        end
      end
    end
    total++;
    if (en_cycles != 0 || end_done !== 1'b1) begin
      bad++;
      $display("FAIL gap_status: got en_cycles=%0d done=%0b need 0,1", en_cycles, end_done);
    end
  endtask

  task automatic test_illegal;
    fill_mem(3'b100);
    mem[3][3] = 3'b000;
    run_trace(3, 3, 100, 0, 0);
    total++;
    if (end_err !== 1'b1 || end_done !== 1'b0 || cap_op.size() != 0) begin
      bad++;
      $display("FAIL illegal_symbol: got err=%0b done=%0b steps=%0d need 1,0,0",
               end_err, end_done, cap_op.size());
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0 || error !== 1'b1) begin
        bad++;
        $display("FAIL illegal_quiet: got v=%0b err=%0b need 0,1", out_valid, error);
      end
    end
  endtask

  task automatic test_stall;
    int t0;
    fill_mem(3'b100);
    t0 = total;
    run_trace(4, 4, 100, 5, 0);
    total++;
    if (total - t0 < 6) begin
      bad++;
      $display("FAIL stall_holds: got %0d hold checks need at least 5", total - t0 - 1);
    end
    total++;
    if (cap_op.size() != 4 || cap_i[0] != 4 || cap_j[0] != 4 || cap_i[1] != 3) begin
      bad++;
      $display("FAIL stall_steps: got %0d steps need 4 starting (4,4),(3,3)", cap_op.size());
    end
  endtask

  task automatic test_reset_mid;
    fill_mem(3'b100);
    @(negedge clk);
    len_a = 4; len_b = 4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    total++;
    if ({en_traceB, out_valid, out_op, out_i, out_j, busy, done, error} !== '0) begin
      bad++;
      $display("FAIL reset_mid: en=%0b v=%0b op=%0d i=%0d j=%0d busy=%0b done=%0b err=%0b need all 0",
               en_traceB, out_valid, out_op, out_i, out_j, busy, done, error);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL reset_idle: got v=%0b busy=%0b need 0,0", out_valid, busy);
      end
    end
    run_trace(4, 4, 100, 0, 0);
    model_trace(4, 4);
    total++;
    if (cap_op != exp_op || cap_i != exp_i || cap_j != exp_j || end_done !== exp_done) begin
      bad++;
      $display("FAIL reset_restart: got %0d steps first=(%0d,%0d) need %0d steps from (4,4)",
               cap_op.size(), cap_i.size() ? cap_i[0] : -1, cap_j.size() ? cap_j[0] : -1, exp_op.size());
    end
  endtask

  task automatic test_mixed;
    fill_mem(3'b000);
    mem[4][4] = 3'b100; mem[3][3] = 3'b001; mem[3][2] = 3'b010;
    mem[2][2] = 3'b100; mem[1][1] = 3'b100;
    run_trace(4, 4, 80, 0, 1);
    exp_op = {0, 2, 1, 0, 0}; exp_i = {4, 3, 3, 2, 1}; exp_j = {4, 3, 2, 2, 1};
    total++;
    if (cap_op.size() != 5) begin
      bad++;
      $display("FAIL mixed_count: got %0d steps need 5", cap_op.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        total++;
        if (cap_op[k] != exp_op[k] || cap_i[k] != exp_i[k] || cap_j[k] != exp_j[k]) begin
          bad++;
          $display("FAIL mixed_step%0d: got op=%0d (%0d,%0d) need op=%0d (%0d,%0d)",
                   k, cap_op[k], cap_i[k], cap_j[k], exp_op[k], exp_i[k], exp_j[k]);
        end
      end
    end
    total++;
    if (end_done !== 1'b1 || end_err !== 1'b0) begin
      bad++;
      $display("FAIL mixed_status: got done=%0b err=%0b need 1,0", end_done, end_err);
    end
  endtask

  task automatic test_random;
    int a, b, r;
    for (int it = 0; it < 30; it++) begin
      for (int x = 0; x <= N; x++)
        for (int y = 0; y <= N; y++) begin
          r = $urandom_range(19);
          mem[x][y] = (r < 6) ? 3'b100 : (r < 12) ? 3'b010 : (r < 18) ? 3'b001 : 3'($urandom_range(7));
        end
      a = $urandom_range(N + 1);
      b = $urandom_range(N + 1);
      run_trace(a, b, 65, 0, it[0]);
      model_trace(a, b);
      total++;
      if (cap_op != exp_op || cap_i != exp_i || cap_j != exp_j ||
          end_done !== exp_done || end_err !== exp_err) begin
        bad++;
        $display("FAIL random%0d len=%0d/%0d: got %0d steps done=%0b err=%0b need %0d steps done=%0b err=%0b",
                 it, a, b, cap_op.size(), end_done, end_err, exp_op.size(), exp_done, exp_err);
      end
    end
  endtask

  task automatic test_back_to_back;
    fill_mem(3'b010);
    run_trace(3, 1, 100, 0, 0);
    run_trace(0, 2, 100, 0, 0);
    total++;
    if (cap_op.size() != 2 || cap_op[0] != 2 || cap_j[0] != 2 || cap_op[1] != 2 || cap_j[1] != 1) begin
      bad++;
      $display("FAIL back_to_back: got %0d steps need 2 left steps at (0,2),(0,1)", cap_op.size());
    end
    run_trace(5, 1, 100, 0, 0);
    total++;
    if (end_err !== 1'b1 || end_done !== 1'b0 || cap_op.size() != 0) begin
      bad++;
      $display("FAIL oversize_len: got err=%0b done=%0b steps=%0d need 1,0,0",
               end_err, end_done, cap_op.size());
    end
  endtask

  initial begin
    test_reset();
    test_diagonal();
    test_latency();
    test_gap_only();
    test_illegal();
    test_stall();
    test_reset_mid();
    test_mixed();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
